// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmitter: parity modes,
// transmit FSM states and a frame-length helper.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } tx_state_t;

  // Number of bit periods in one frame: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; full/empty/level are derived
// only from the pointer registers, so they never depend on same-cycle requests.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [WIDTH-1:0]        i_din,
  output logic [WIDTH-1:0]        o_dout,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
  assign o_level   = r_wr_ptr - r_rd_ptr;

  // Pointer update; a push while full is dropped without touching the queue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      end
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: characters are queued in sync_fifo and
// serialised LSB first with configurable width, parity and stop bits.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD_RATE   = 1_000_000,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [DATA_W-1:0]       i_data,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic                    o_busy,
  output logic                    o_uart_tx
);

  localparam int DIV        = CLK_FREQ_HZ / BAUD_RATE;
  localparam int BW         = $clog2(DIV);
  localparam int FRAME_BITS = frame_bits(DATA_W, PARITY, STOP_BITS);
  localparam int CW         = $clog2(FRAME_BITS + 1);

  tx_state_t         r_state;
  logic [BW-1:0]     r_baud;
  logic [CW-1:0]     r_bit;
  logic [DATA_W-1:0] r_shift;
  logic              r_par;
  logic              r_tx;

  logic [DATA_W-1:0] w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_baud_end;
  logic              w_data_last;
  logic              w_stop_last;

  function automatic logic calc_parity(input logic [DATA_W-1:0] d);
    return (^d) ^ (PARITY == PARITY_ODD);
  endfunction

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_push  (i_valid),
    .i_pop   (w_pop),
    .i_din   (i_data),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (o_level)
  );

  assign w_baud_end  = (r_baud == BW'(DIV - 1));
  assign w_data_last = (r_bit == CW'(DATA_W - 1));
  assign w_stop_last = (r_bit == CW'(STOP_BITS - 1));

  // Pop from IDLE, or on the final stop-bit cycle so the next start follows with no gap.
  always_comb begin
    w_pop = 1'b0;
    if (w_empty) begin
      w_pop = 1'b0;
    end else if (r_state == IDLE) begin
      w_pop = 1'b1;
    end else if ((r_state == STOP) && w_baud_end && w_stop_last) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end
  end

  // Transmit FSM; the line is registered and forced high by the async reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_baud <= '0;
          r_bit  <= '0;
          if (w_pop) begin
            r_shift <= w_dout;
            r_par   <= calc_parity(w_dout);
            r_state <= START;
            r_tx    <= 1'b0;
          end else begin
            r_tx <= 1'b1;
          end
        end
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_tx    <= r_shift[0];
            r_state <= DATA;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_data_last) begin
              r_bit <= '0;
              if (PARITY != PARITY_NONE) begin
                r_state <= PAR;
                r_tx    <= r_par;
              end else begin
                r_state <= STOP;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + CW'(1);
              r_shift <= {1'b0, r_shift[DATA_W-1:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        PAR: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= STOP;
            r_tx    <= 1'b1;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (w_stop_last) begin
              r_bit <= '0;
              if (w_pop) begin
                r_shift <= w_dout;
                r_par   <= calc_parity(w_dout);
                r_state <= START;
                r_tx    <= 1'b0;
              end else begin
                r_state <= IDLE;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit <= r_bit + CW'(1);
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_baud  <= '0;
          r_bit   <= '0;
          r_tx    <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready   = !w_full;
  assign o_busy    = (r_state != IDLE) || !w_empty;
  assign o_uart_tx = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: four transmitter configurations compared cycle by
// cycle against a queue-and-frame-timer model of the line protocol.
module tb_uart_tx_fifo;

  localparam int DIV = 10;
  localparam int P_DW  [4] = '{8, 8, 8, 7};
  localparam int P_PAR [4] = '{0, 1, 2, 0};
  localparam int P_SB  [4] = '{1, 1, 1, 2};
  localparam int P_DEP [4] = '{16, 4, 16, 4};

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       vld [4];
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic       r0, r1, r2, r3;
  logic       b0, b1, b2, b3;
  logic       t0, t1, t2, t3;
  logic [4:0] l0, l2;
  logic [2:0] l1, l3;

  int checks = 0;
  int passes = 0;

  int mq [4][$];
  bit m_act [4];
  int m_t   [4];
  int m_dat [4];

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ_HZ(10_000_000), .BAUD_RATE(1_000_000)) u0 (
    .clk(clk), .resetn(resetn), .i_data(d0), .i_valid(vld[0]), .o_ready(r0),
    .o_level(l0), .o_busy(b0), .o_uart_tx(t0));
  uart_tx_fifo #(.DEPTH(4), .PARITY(1)) u1 (
    .clk(clk), .resetn(resetn), .i_data(d1), .i_valid(vld[1]), .o_ready(r1),
    .o_level(l1), .o_busy(b1), .o_uart_tx(t1));
  uart_tx_fifo #(.PARITY(2)) u2 (
    .clk(clk), .resetn(resetn), .i_data(d2), .i_valid(vld[2]), .o_ready(r2),
    .o_level(l2), .o_busy(b2), .o_uart_tx(t2));
  uart_tx_fifo #(.DATA_W(7), .STOP_BITS(2), .DEPTH(4)) u3 (
    .clk(clk), .resetn(resetn), .i_data(d3), .i_valid(vld[3]), .o_ready(r3),
    .o_level(l3), .o_busy(b3), .o_uart_tx(t3));

  function automatic int data_of(int k);
    case (k)
      0: return int'(d0);
      1: return int'(d1);
      2: return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  function automatic logic [31:0] act_tx(int k);
    case (k)
      0: return {31'b0, t0};
      1: return {31'b0, t1};
      2: return {31'b0, t2};
      default: return {31'b0, t3};
    endcase
  endfunction

  function automatic logic [31:0] act_lvl(int k);
    case (k)
      0: return {27'b0, l0};
      1: return {29'b0, l1};
      2: return {27'b0, l2};
      default: return {29'b0, l3};
    endcase
  endfunction

  function automatic logic [31:0] act_rdy(int k);
    case (k)
      0: return {31'b0, r0};
      1: return {31'b0, r1};
      2: return {31'b0, r2};
      default: return {31'b0, r3};
    endcase
  endfunction

  function automatic logic [31:0] act_busy(int k);
    case (k)
      0: return {31'b0, b0};
      1: return {31'b0, b1};
      2: return {31'b0, b2};
      default: return {31'b0, b3};
    endcase
  endfunction

  function automatic int flen(int k);
    return (1 + P_DW[k] + ((P_PAR[k] != 0) ? 1 : 0) + P_SB[k]) * DIV;
  endfunction

  // Expected line level from the position inside the current frame.
  function automatic logic exp_line(int k);
    int b;
    int ones;
    if (!m_act[k]) return 1'b1;
    b = m_t[k] / DIV;
    if (b == 0) return 1'b0;
    if (b <= P_DW[k]) return 1'((m_dat[k] >> (b - 1)) & 1);
    if ((P_PAR[k] != 0) && (b == P_DW[k] + 1)) begin
      ones = 0;
      for (int i = 0; i < P_DW[k]; i++) ones += (m_dat[k] >> i) & 1;
      return (P_PAR[k] == 1) ? 1'(ones % 2) : 1'((ones + 1) % 2);
    end
    return 1'b1;
  endfunction

  function automatic bit all_idle();
    for (int k = 0; k < 4; k++) begin
      if (m_act[k] || (mq[k].size() > 0)) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      mq[k].delete();
      m_act[k] = 1'b0;
      m_t[k]   = 0;
      m_dat[k] = 0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 4; k++) begin
      int sz;
      bit acc;
      sz  = mq[k].size();
      acc = vld[k] && (sz < P_DEP[k]);
      if (m_act[k]) begin
        if (m_t[k] == flen(k) - 1) m_act[k] = 1'b0;
        else m_t[k]++;
      end
      if (!m_act[k] && (sz > 0)) begin
        m_dat[k] = mq[k].pop_front();
        m_act[k] = 1'b1;
        m_t[k]   = 0;
      end
      if (acc) mq[k].push_back(data_of(k) & ((1 << P_DW[k]) - 1));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (resetn) model_edge();
    else model_reset();
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (act_tx(k) !== 32'd1) $display("FAIL reset_tx u%0d got %0d want 1", k, act_tx(k));
      else passes++;
      checks++;
      if (act_rdy(k) !== 32'd1) $display("FAIL reset_ready u%0d got %0d want 1", k, act_rdy(k));
      else passes++;
      checks++;
      if (act_lvl(k) !== 32'd0) $display("FAIL reset_level u%0d got %0d want 0", k, act_lvl(k));
      else passes++;
      checks++;
      if (act_busy(k) !== 32'd0) $display("FAIL reset_busy u%0d got %0d want 0", k, act_busy(k));
      else passes++;
    end
    resetn = 1'b1;
  endtask

  task automatic test_drain();
    int c;
    for (c = 0; (c < 4000) && !all_idle(); c++) begin
      step();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act_tx(k) !== {31'b0, exp_line(k)})
          $display("FAIL drain_line u%0d t=%0t got %0d want %0d", k, $time, act_tx(k), exp_line(k));
        else passes++;
        checks++;
        if (act_lvl(k) !== 32'(mq[k].size()))
          $display("FAIL drain_level u%0d t=%0t got %0d want %0d", k, $time, act_lvl(k), mq[k].size());
        else passes++;
        checks++;
        if (act_busy(k) !== {31'b0, (m_act[k] || (mq[k].size() > 0))})
          $display("FAIL drain_busy u%0d t=%0t got %0d want %0d", k, $time, act_busy(k), m_act[k]);
        else passes++;
      end
    end
    checks++;
    if (!all_idle()) $display("FAIL drain_timeout cycles got %0d want <4000", c);
    else passes++;
    repeat (3) step();
  endtask

  task automatic test_single_frame();
    localparam bit PAT [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int busy_cnt = 0;
    int low_cnt = 0;
    d0 = 8'h55; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    for (int c = 0; c < 115; c++) begin
      if (c > 0) step();
      checks++;
      if (t0 !== exp_line(0)) $display("FAIL single_line c=%0d got %0d want %0d", c, t0, exp_line(0));
      else passes++;
      if ((c % 10 == 6) && (c <= 96)) begin
        checks++;
        if (t0 !== PAT[(c - 6) / 10]) $display("FAIL single_sample c=%0d got %0d want %0d", c, t0, PAT[(c - 6) / 10]);
        else passes++;
      end
      if (b0 === 1'b1) busy_cnt++;
      if (t0 === 1'b0) low_cnt++;
    end
    checks++;
    if (busy_cnt != 101) $display("FAIL single_busy_len got %0d want 101", busy_cnt);
    else passes++;
    checks++;
    if (low_cnt != 50) $display("FAIL single_low_len got %0d want 50", low_cnt);
    else passes++;
  endtask

  task automatic test_burst();
    int busy_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      d1 = 8'h41 + 8'(i); vld[1] = 1'b1;
      step();
      if (b1 === 1'b1) busy_cnt++;
      checks++;
      if (act_lvl(1) !== 32'(mq[1].size())) $display("FAIL burst_level i=%0d got %0d want %0d", i, l1, mq[1].size());
      else passes++;
      checks++;
      if (r1 !== (mq[1].size() < 4)) $display("FAIL burst_ready i=%0d got %0d want %0d", i, r1, mq[1].size() < 4);
      else passes++;
    end
    vld[1] = 1'b0;
    checks++;
    if (l1 !== 3'd4) $display("FAIL burst_full_level got %0d want 4", l1);
    else passes++;
    checks++;
    if (r1 !== 1'b0) $display("FAIL burst_full_ready got %0d want 0", r1);
    else passes++;
    for (int c = 0; c < 600; c++) begin
      step();
      if (b1 === 1'b1) busy_cnt++;
      checks++;
      if (t1 !== exp_line(1)) $display("FAIL burst_line c=%0d got %0d want %0d", c, t1, exp_line(1));
      else passes++;
    end
    checks++;
    if (busy_cnt != 551) $display("FAIL burst_busy_len got %0d want 551", busy_cnt);
    else passes++;
  endtask

  task automatic test_parity();
    int busy1 = 0;
    int busy2 = 0;
    d1 = 8'h07; d2 = 8'h07; vld[1] = 1'b1; vld[2] = 1'b1;
    step();
    vld[1] = 1'b0; vld[2] = 1'b0;
    for (int c = 0; c < 130; c++) begin
      if (c > 0) step();
      if (b1 === 1'b1) busy1++;
      if (b2 === 1'b1) busy2++;
      checks++;
      if (t1 !== exp_line(1)) $display("FAIL even_line c=%0d got %0d want %0d", c, t1, exp_line(1));
      else passes++;
      checks++;
      if (t2 !== exp_line(2)) $display("FAIL odd_line c=%0d got %0d want %0d", c, t2, exp_line(2));
      else passes++;
      if (c == 96) begin
        checks++;
        if (t1 !== 1'b1) $display("FAIL even_parity_bit got %0d want 1", t1);
        else passes++;
        checks++;
        if (t2 !== 1'b0) $display("FAIL odd_parity_bit got %0d want 0", t2);
        else passes++;
      end
    end
    checks++;
    if (busy1 != 111) $display("FAIL even_frame_len got %0d want 111", busy1);
    else passes++;
    checks++;
    if (busy2 != 111) $display("FAIL odd_frame_len got %0d want 111", busy2);
    else passes++;
  endtask

  task automatic test_stop_bits();
    int start_low = 0;
    int stop_high = 0;
    d3 = 7'h7F; vld[3] = 1'b1;
    step();
    d3 = 7'h00;
    step();
    vld[3] = 1'b0;
    for (int c = 2; c < 110; c++) begin
      step();
      checks++;
      if (t3 !== exp_line(3)) $display("FAIL stop2_line c=%0d got %0d want %0d", c, t3, exp_line(3));
      else passes++;
      if ((c >= 81) && (c <= 100) && (t3 === 1'b1)) stop_high++;
      if (c == 101) begin
        checks++;
        if (t3 !== 1'b0) $display("FAIL stop2_next_start got %0d want 0", t3);
        else passes++;
      end
    end
    checks++;
    if (stop_high != 20) $display("FAIL stop2_high_len got %0d want 20", stop_high);
    else passes++;
    start_low = 0;
    checks++;
    if (l3 !== 3'(start_low)) $display("FAIL stop2_level got %0d want 0", l3);
    else passes++;
  endtask

  task automatic test_simul_push_pop();
    d0 = 8'hA1; vld[0] = 1'b1; step();
    d0 = 8'hB2; step();
    d0 = 8'hC3; step();
    vld[0] = 1'b0;
    for (int s = 4; s <= 101; s++) begin
      step();
      checks++;
      if (t0 !== exp_line(0)) $display("FAIL simul_line s=%0d got %0d want %0d", s, t0, exp_line(0));
      else passes++;
    end
    checks++;
    if ((l0 !== 5'd2) || (t0 !== 1'b1)) $display("FAIL simul_before level=%0d line=%0d want 2,1", l0, t0);
    else passes++;
    d0 = 8'hD4; vld[0] = 1'b1;
    step();
    vld[0] = 1'b0;
    checks++;
    if (l0 !== 5'd2) $display("FAIL simul_level got %0d want 2", l0);
    else passes++;
    checks++;
    if (t0 !== 1'b0) $display("FAIL simul_no_gap got %0d want 0", t0);
    else passes++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 4; k++) vld[k] = ($urandom_range(0, 99) < ((c < 1500) ? 25 : 2));
      d0 = 8'($urandom); d1 = 8'($urandom); d2 = 8'($urandom); d3 = 7'($urandom);
      step();
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (act_tx(k) !== {31'b0, exp_line(k)})
          $display("FAIL rand_line u%0d t=%0t got %0d want %0d", k, $time, act_tx(k), exp_line(k));
        else passes++;
        checks++;
        if (act_lvl(k) !== 32'(mq[k].size()))
          $display("FAIL rand_level u%0d t=%0t got %0d want %0d", k, $time, act_lvl(k), mq[k].size());
        else passes++;
        checks++;
        if (act_rdy(k) !== {31'b0, (mq[k].size() < P_DEP[k])})
          $display("FAIL rand_ready u%0d t=%0t got %0d want %0d", k, $time, act_rdy(k), mq[k].size() < P_DEP[k]);
        else passes++;
        checks++;
        if (act_busy(k) !== {31'b0, (m_act[k] || (mq[k].size() > 0))})
          $display("FAIL rand_busy u%0d t=%0t got %0d want %0d", k, $time, act_busy(k), m_act[k]);
        else passes++;
      end
    end
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;
  endtask

  task automatic test_reset_midframe();
    int highs = 0;
    d0 = 8'h00; vld[0] = 1'b1; step();
    d0 = 8'h11; step();
    d0 = 8'h22; step();
    vld[0] = 1'b0;
    repeat (34) step();
    checks++;
    if (t0 !== 1'b0) $display("FAIL midframe_line got %0d want 0", t0);
    else passes++;
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (t0 !== 1'b1) $display("FAIL async_reset_line got %0d want 1", t0);
    else passes++;
    checks++;
    if ((l0 !== 5'd0) || (r0 !== 1'b1) || (b0 !== 1'b0))
      $display("FAIL async_reset_status level=%0d ready=%0d busy=%0d want 0,1,0", l0, r0, b0);
    else passes++;
    repeat (2) step();
    resetn = 1'b1;
    for (int c = 0; c < 200; c++) begin
      step();
      if ((t0 === 1'b1) && (b0 === 1'b0) && (l0 === 5'd0) && (r0 === 1'b1)) highs++;
    end
    checks++;
    if (highs != 200) $display("FAIL post_reset_quiet got %0d want 200", highs);
    else passes++;
  endtask

  initial begin
    for (int k = 0; k < 4; k++) vld[k] = 1'b0;
    d0 = 8'h00; d1 = 8'h00; d2 = 8'h00; d3 = 7'h00;
    test_reset();
    test_single_frame();
    test_drain();
    test_burst();
    test_drain();
    test_parity();
    test_drain();
    test_stop_bits();
    test_drain();
    test_simul_push_pop();
    test_drain();
    test_random();
    test_drain();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
